// File: rtl/clkgate_seq_pkg.sv
// Shared types and sizing helpers for the clock-gate sequencer.
//   dom_state_e : per-domain lifecycle (OFF -> PEND -> WAKING -> ON)
//   seq_state_e : wake sequencer (IDLE / SETTLE)
//   cnt_w()     : bits needed to hold a down-counter loaded with n
package clkgate_seq_pkg;

  typedef enum logic [1:0] {OFF, PEND, WAKING, ON} dom_state_e;
  typedef enum logic       {IDLE, SETTLE}          seq_state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Widths for the default configuration; modules size their own
  // counters with cnt_w() from their actual parameters.
  localparam int DEF_IDLE_CYCLES   = 16;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int IDLE_W            = cnt_w(DEF_IDLE_CYCLES);
  localparam int SETTLE_W          = cnt_w(DEF_SETTLE_CYCLES);

endpackage

// File: rtl/gate_domain_ctrl.sv
// Per-domain controller: owns one clock gate's lifecycle, its idle
// timer and the registered enable / ready outputs.
// Ports:
//   i_clk, i_rst      : root clock, synchronous active-high reset
//   i_req, i_force_on : activity request for this domain / global override
//   i_grant           : sequencer picked this domain to wake this cycle
//   i_settle_done     : current settle interval ends this cycle
//   o_candidate       : domain wants a wake slot
//   o_gate_en         : registered enable to the clock-gate cell
//   o_gate_ready      : gate enabled and settled
module gate_domain_ctrl
  import clkgate_seq_pkg::*;
#(
  parameter int IDLE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_force_on,
  input  logic i_grant,
  input  logic i_settle_done,
  output logic o_candidate,
  output logic o_gate_en,
  output logic o_gate_ready
);

  localparam int IW = cnt_w(IDLE_CYCLES);

  dom_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic          r_gate_en, w_gate_en_nxt;
  logic          r_gate_ready, w_gate_ready_nxt;
  logic          w_act;

  assign w_act        = i_req | i_force_on;
  assign o_candidate  = (r_state == PEND) | ((r_state == OFF) & w_act);
  assign o_gate_en    = r_gate_en;
  assign o_gate_ready = r_gate_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_idle_cnt_nxt   = r_idle_cnt;
    w_gate_en_nxt    = r_gate_en;
    w_gate_ready_nxt = r_gate_ready;
    unique case (r_state)
      OFF: begin
        if (i_grant) begin
          w_state_nxt   = WAKING;
          w_gate_en_nxt = 1'b1;
        end else if (w_act) begin
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        // Request level no longer matters: a pending wake always completes.
        if (i_grant) begin
          w_state_nxt   = WAKING;
          w_gate_en_nxt = 1'b1;
        end
      end
      WAKING: begin
        if (i_settle_done) begin
          w_state_nxt      = ON;
          w_gate_ready_nxt = 1'b1;
          w_idle_cnt_nxt   = IW'(IDLE_CYCLES);
        end
      end
      ON: begin
        // A request counts as the first of the idle window, so reload one
        // short; entry into ON loads the full value since the ON cycle
        // itself is the first idle cycle observed.
        if (w_act) begin
          w_idle_cnt_nxt = IW'(IDLE_CYCLES - 1);
        end else if (r_idle_cnt == '0) begin
          w_state_nxt      = OFF;
          w_gate_en_nxt    = 1'b0;
          w_gate_ready_nxt = 1'b0;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt - IW'(1);
        end
      end
      default: w_state_nxt = OFF;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= OFF;
      r_idle_cnt   <= '0;
      r_gate_en    <= 1'b0;
      r_gate_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_gate_en    <= w_gate_en_nxt;
      r_gate_ready <= w_gate_ready_nxt;
    end
  end

endmodule

// File: rtl/clock_gate_sequencer.sv
// Enable controller for a bank of clock-gate cells. Domains wake on
// request one at a time (round-robin, each followed by a settle interval
// to limit clock-tree inrush) and sleep after an idle timeout.
// Ports:
//   clk        : ungated root clock
//   rst        : synchronous active-high reset
//   req        : per-domain activity request (level)
//   force_on   : wake every domain, suppress idle timeout
//   gate_en    : registered enable per clock-gate cell
//   gate_ready : domain enabled and settled
//   seq_busy   : a wake settle interval is running
module clock_gate_sequencer
  import clkgate_seq_pkg::*;
#(
  parameter int NUM_GATES     = 5,
  parameter int IDLE_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_GATES-1:0] req,
  input  logic                 force_on,
  output logic [NUM_GATES-1:0] gate_en,
  output logic [NUM_GATES-1:0] gate_ready,
  output logic                 seq_busy
);

  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int PW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;

  seq_state_e           r_seq, w_seq_nxt;
  logic [SW-1:0]        r_settle_cnt, w_settle_cnt_nxt;
  logic [PW-1:0]        r_ptr, w_ptr_nxt;
  logic [NUM_GATES-1:0] w_cand, w_grant;
  logic                 w_settle_done;
  logic                 w_hit_hi, w_hit_lo, w_any;
  logic [PW-1:0]        w_sel_hi, w_sel_lo, w_sel;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_dom
    gate_domain_ctrl #(
      .IDLE_CYCLES(IDLE_CYCLES)
    ) u_dom (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req        (req[g]),
      .i_force_on   (force_on),
      .i_grant      (w_grant[g]),
      .i_settle_done(w_settle_done),
      .o_candidate  (w_cand[g]),
      .o_gate_en    (gate_en[g]),
      .o_gate_ready (gate_ready[g])
    );
  end

  // Round-robin pick: lowest candidate at/after the pointer, else the
  // lowest candidate below it (wrap). Scanning downward leaves the
  // lowest index in each half.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_sel_hi = '0;
    w_sel_lo = '0;
    for (int i = NUM_GATES - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        if (PW'(i) >= r_ptr) begin
          w_hit_hi = 1'b1;
          w_sel_hi = PW'(i);
        end else begin
          w_hit_lo = 1'b1;
          w_sel_lo = PW'(i);
        end
      end
    end
    w_any = w_hit_hi | w_hit_lo;
    w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;
  end

  assign w_grant       = (r_seq == IDLE && w_any) ? (NUM_GATES'(1) << w_sel) : '0;
  assign w_settle_done = (r_seq == SETTLE) && (r_settle_cnt == SW'(1));
  assign seq_busy      = (r_seq == SETTLE);

  always_comb begin
    w_seq_nxt        = r_seq;
    w_settle_cnt_nxt = r_settle_cnt;
    w_ptr_nxt        = r_ptr;
    unique case (r_seq)
      IDLE: begin
        if (w_any) begin
          w_seq_nxt        = SETTLE;
          w_settle_cnt_nxt = SW'(SETTLE_CYCLES);
          w_ptr_nxt        = (w_sel == PW'(NUM_GATES - 1)) ? '0 : w_sel + PW'(1);
        end
      end
      SETTLE: begin
        if (w_settle_done) begin
          w_seq_nxt        = IDLE;
          w_settle_cnt_nxt = '0;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt - SW'(1);
        end
      end
      default: w_seq_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq        <= IDLE;
      r_settle_cnt <= '0;
      r_ptr        <= '0;
    end else begin
      r_seq        <= w_seq_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_ptr        <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_clock_gate_sequencer.sv
// Bench for clock_gate_sequencer: directed scenarios plus random traffic,
// every cycle compared against a timestamp-based reference model.
module tb_clock_gate_sequencer;

  localparam int N    = 5;
  localparam int IDLE = 16;
  localparam int SET  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         force_on = 1'b0;
  logic [N-1:0] gate_en, gate_ready;
  logic         seq_busy;

  clock_gate_sequencer #(
    .NUM_GATES(N), .IDLE_CYCLES(IDLE), .SETTLE_CYCLES(SET)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .force_on(force_on),
    .gate_en(gate_en), .gate_ready(gate_ready), .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: outputs for cycle 'cyc' plus timestamps.
  bit m_en[N], m_rdy[N], m_pend[N];
  int m_dl[N];      // last cycle the gate stays on without a new request
  int m_ptr, m_free, m_bstart, m_wk, m_rdyat;

  int           rise[N];
  logic [N-1:0] prev_en = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [N-1:0] pk(input bit a[N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_next(input logic r, input logic [N-1:0] q, input logic f, input int t);
    bit act[N];
    bit n_en[N], n_rdy[N], n_pend[N];
    int n_dl[N];
    int w, ii;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_rdy[i] = 0; m_pend[i] = 0; m_dl[i] = 0;
      end
      m_ptr = 0; m_free = 0; m_bstart = 0; m_wk = -1; m_rdyat = 0;
      return;
    end
    n_en = m_en; n_rdy = m_rdy; n_pend = m_pend; n_dl = m_dl;
    for (int i = 0; i < N; i++) act[i] = q[i] | f;
    // idle timeout of settled domains
    for (int i = 0; i < N; i++) begin
      if (m_rdy[i]) begin
        if (act[i]) n_dl[i] = t + IDLE;
        else if (t == m_dl[i]) begin n_en[i] = 0; n_rdy[i] = 0; end
      end
    end
    // end of a settle interval
    if (m_wk >= 0 && t + 1 == m_rdyat) begin
      n_rdy[m_wk] = 1;
      n_dl[m_wk]  = m_rdyat + IDLE;
      m_wk = -1;
    end
    // new wake allowed once the previous settle window has elapsed
    w = -1;
    if (t >= m_free) begin
      for (int k = 0; k < N; k++) begin
        ii = (m_ptr + k) % N;
        if (w < 0 && (m_pend[ii] || (!m_en[ii] && act[ii]))) w = ii;
      end
    end
    if (w >= 0) begin
      n_en[w] = 1; n_pend[w] = 0;
      m_wk = w; m_rdyat = t + 1 + SET;
      m_bstart = t + 1; m_free = t + 1 + SET;
      m_ptr = (w + 1) % N;
    end
    for (int i = 0; i < N; i++)
      if (i != w && !m_en[i] && !m_pend[i] && act[i]) n_pend[i] = 1;
    m_en = n_en; m_rdy = n_rdy; m_pend = n_pend; m_dl = n_dl;
  endtask

  task automatic step(input logic r, input logic [N-1:0] q, input logic f);
    rst = r; req = q; force_on = f;
    model_next(r, q, f, cyc);
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (gate_en[i] && !prev_en[i]) rise[i] = cyc;
    prev_en = gate_en;
    chk("gate_en", 32'(gate_en), 32'(pk(m_en)));
    chk("gate_ready", 32'(gate_ready), 32'(pk(m_rdy)));
    chk("seq_busy", 32'(seq_busy), 32'(cyc >= m_bstart && cyc < m_free));
    chk("ready_wo_en", 32'(gate_ready & ~gate_en), 32'd0);
  endtask

  task automatic clr_rise();
    for (int i = 0; i < N; i++) rise[i] = -1;
  endtask

  int t0;

  initial begin
    clr_rise();
    // Reset held with all requests high: nothing may wake.
    repeat (3) step(1'b1, 5'b11111, 1'b0);

    // Single wake and idle timeout on domain 2.
    t0 = cyc;
    step(1'b0, 5'b00100, 1'b0);
    for (int k = 1; k < 30; k++) begin
      step(1'b0, '0, 1'b0);
      if (cyc == t0 + 21) chk("single_en_last", 32'(gate_en[2]), 32'd1);
      if (cyc == t0 + 22) chk("single_en_off", 32'(gate_en[2]), 32'd0);
      if (cyc == t0 + 5)  chk("single_ready", 32'(gate_ready[2]), 32'd1);
    end

    // Contention from a fresh reset: order 0..4, five cycles apart.
    repeat (2) step(1'b1, '0, 1'b0);
    clr_rise();
    t0 = cyc;
    repeat (30) step(1'b0, 5'b11111, 1'b0);
    for (int i = 0; i < N; i++) chk("contend_rise", 32'(rise[i] - t0), 32'(1 + 5 * i));

    // Round-robin: 3 granted, then 1 and 4 together -> 4 before 1.
    repeat (2) step(1'b1, '0, 1'b0);
    clr_rise();
    t0 = cyc;
    step(1'b0, 5'b01000, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, 5'b10010, 1'b0);
    repeat (15) step(1'b0, '0, 1'b0);
    chk("rr_rise3", 32'(rise[3] - t0), 32'd1);
    chk("rr_rise4", 32'(rise[4] - t0), 32'd6);
    chk("rr_rise1", 32'(rise[1] - t0), 32'd11);

    // Timeout race: re-request exactly when the idle count expires.
    repeat (2) step(1'b1, '0, 1'b0);
    t0 = cyc;
    step(1'b0, 5'b00001, 1'b0);
    repeat (20) step(1'b0, '0, 1'b0);
    step(1'b0, 5'b00001, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0);
    chk("race_hold", 32'(gate_en[0]), 32'd1);
    repeat (12) step(1'b0, '0, 1'b0);
    chk("race_off", 32'(gate_en[0]), 32'd0);

    // force_on with no requests: everyone wakes, nobody times out.
    repeat (2) step(1'b1, '0, 1'b0);
    repeat (70) step(1'b0, '0, 1'b1);
    chk("force_en", 32'(gate_en), 32'h1f);
    chk("force_ready", 32'(gate_ready), 32'h1f);

    // Reset during the third settle, then pointer back at domain 0.
    repeat (2) step(1'b1, '0, 1'b0);
    t0 = cyc;
    repeat (12) step(1'b0, '0, 1'b1);
    chk("mid_busy", 32'(seq_busy), 32'd1);
    step(1'b1, '0, 1'b1);
    chk("rst_mid_en", 32'(gate_en), 32'd0);
    chk("rst_mid_busy", 32'(seq_busy), 32'd0);
    clr_rise();
    t0 = cyc;
    repeat (3) step(1'b0, '0, 1'b1);
    chk("ptr_reset_rise0", 32'(rise[0] - t0), 32'd1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] q;
      for (int i = 0; i < N; i++) q[i] = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 499) == 0), q, ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
